tx_dac_pacer: RTL



---
 rtl/tx_dac_pacer_pkg.sv | 22 ++
 rtl/tx_rate_strobe.sv | 28 ++
 rtl/tx_dac_pacer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tx_dac_pacer_pkg.sv
// Shared types and constants for the TX DAC pacing stage.
package tx_dac_pacer_pkg;

  // Ramp state machine encoding.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } pacer_state_t;

  // Gain spans 0..2^MAX_RAMP_LOG2, so it needs one bit more than the log.
  localparam int GAIN_W        = 9;
  localparam int MAX_RAMP_LOG2 = 8;
  localparam int RAMP_LOG2_W   = 4;

  // Limit a requested ramp length exponent to the largest supported ramp.
  function automatic logic [RAMP_LOG2_W-1:0] clamp_ramp_log2(input logic [RAMP_LOG2_W-1:0] k);
    return (k > RAMP_LOG2_W'(MAX_RAMP_LOG2)) ? RAMP_LOG2_W'(MAX_RAMP_LOG2) : k;
  endfunction

endpackage

// File: rtl/tx_rate_strobe.sv
// Phase accumulator that emits a registered one-cycle strobe on each carry-out.
// Strobe rate is f_clk * rate_step / 2^ACC_WIDTH; rate_step = 0 stops it.
module tx_rate_strobe #(
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [ACC_WIDTH-1:0] rate_step,
  output logic                 strobe
);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   acc_sum;

  assign acc_sum = {1'b0, acc} + {1'b0, rate_step};

  // Advance the phase every cycle; the carry becomes next cycle's strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc    <= '0;
      strobe <= 1'b0;
    end else begin
      acc    <= acc_sum[ACC_WIDTH-1:0];
      strobe <= acc_sum[ACC_WIDTH];
    end
  end

endmodule

// File: rtl/tx_dac_pacer.sv
// Paces TX I/Q samples to the DAC at a programmable rate and applies a
// linear power ramp at burst start and end, keyed on tx_active.
//
// Upstream handshake: the source is first-word-fall-through. wifi_iq_ready
// is a one-cycle request strobe; the sample on wifi_iq_pack is consumed on
// the clock edge that ends the cycle in which wifi_iq_ready is high. If
// wifi_iq_valid is low in that cycle, a zero sample is substituted and, when
// the burst is live, counted as an underrun. Output: dac_valid pulses one
// cycle per sample two cycles after the request; dac_i/dac_q hold otherwise.
module tx_dac_pacer
  import tx_dac_pacer_pkg::*;
#(
  parameter int IQ_DATA_WIDTH = 16,
  parameter int ACC_WIDTH     = 16
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [ACC_WIDTH-1:0]            rate_step,
  input  logic [RAMP_LOG2_W-1:0]          ramp_len_log2,
  input  logic                            iq_swap,
  input  logic                            tx_active,
  input  logic [2*IQ_DATA_WIDTH-1:0]      wifi_iq_pack,
  input  logic                            wifi_iq_valid,
  output logic                            wifi_iq_ready,
  output logic signed [IQ_DATA_WIDTH-1:0] dac_i,
  output logic signed [IQ_DATA_WIDTH-1:0] dac_q,
  output logic                            dac_valid,
  output logic                            busy,
  output logic [15:0]                     underrun_cnt,
  input  logic                            underrun_clr,
  output pacer_state_t                    dbg_state
);

  localparam int                PROD_W = IQ_DATA_WIDTH + GAIN_W;
  localparam logic [GAIN_W-1:0] G_ONE  = GAIN_W'(1);

  logic                            strobe;
  pacer_state_t                    state, state_nxt;
  logic [GAIN_W-1:0]               gain, gain_nxt, gain_inc, gain_dec, gain_full;
  logic [RAMP_LOG2_W-1:0]          k_in, k_lat, k_eff;
  logic signed [IQ_DATA_WIDTH-1:0] cap_i, cap_q;
  logic                            cap_vld;
  logic signed [PROD_W-1:0]        prod_i, prod_q;
  logic                            underrun_evt;

  tx_rate_strobe #(.ACC_WIDTH(ACC_WIDTH)) u_rate_strobe (
    .clk       (clk),
    .rstn      (rstn),
    .rate_step (rate_step),
    .strobe    (strobe)
  );

  assign wifi_iq_ready = strobe;
  assign busy          = (state != IDLE);
  assign dbg_state     = state;

  // Ramp length is sampled live while idle and frozen for the whole burst.
  assign k_in      = clamp_ramp_log2(ramp_len_log2);
  assign k_eff     = (state == IDLE) ? k_in : k_lat;
  assign gain_full = G_ONE << k_eff;
  assign gain_inc  = gain + G_ONE;
  assign gain_dec  = gain - G_ONE;

  // Next state and gain; transitions only happen on strobe cycles.
  always_comb begin
    state_nxt = state;
    gain_nxt  = gain;
    if (strobe) begin
      case (state)
        IDLE: begin
          gain_nxt = '0;
          if (tx_active) begin
            gain_nxt  = G_ONE;
            state_nxt = (k_eff == '0) ? ON : RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (!tx_active) begin
            gain_nxt  = gain_dec;
            state_nxt = (gain == G_ONE) ? IDLE : RAMP_DOWN;
          end else begin
            gain_nxt = gain_inc;
            if (gain_inc == gain_full) state_nxt = ON;
          end
        end
        ON: begin
          gain_nxt = gain_full;
          if (!tx_active) begin
            gain_nxt  = gain_full - G_ONE;
            state_nxt = (k_eff == '0) ? IDLE : RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          if (tx_active) begin
            gain_nxt  = gain_inc;
            state_nxt = (gain_inc == gain_full) ? ON : RAMP_UP;
          end else begin
            gain_nxt = gain_dec;
            if (gain == G_ONE) state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          gain_nxt  = '0;
        end
      endcase
    end
  end

  // State, gain and latched ramp length registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      gain  <= '0;
      k_lat <= '0;
    end else begin
      state <= state_nxt;
      gain  <= gain_nxt;
      if (state == IDLE && state_nxt != IDLE) k_lat <= k_in;
    end
  end

  // Capture the requested sample (zero if absent), with optional I/Q swap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_i   <= '0;
      cap_q   <= '0;
      cap_vld <= 1'b0;
    end else begin
      cap_vld <= strobe;
      if (strobe) begin
        if (!wifi_iq_valid) begin
          cap_i <= '0;
          cap_q <= '0;
        end else if (iq_swap) begin
          cap_i <= wifi_iq_pack[2*IQ_DATA_WIDTH-1:IQ_DATA_WIDTH];
          cap_q <= wifi_iq_pack[IQ_DATA_WIDTH-1:0];
        end else begin
          cap_i <= wifi_iq_pack[IQ_DATA_WIDTH-1:0];
          cap_q <= wifi_iq_pack[2*IQ_DATA_WIDTH-1:IQ_DATA_WIDTH];
        end
      end
    end
  end

  // Signed sample times unsigned gain; the shift by k floors toward -inf.
  assign prod_i = cap_i * $signed({1'b0, gain});
  assign prod_q = cap_q * $signed({1'b0, gain});

  // Output register: updates once per captured sample, holds in between.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dac_i     <= '0;
      dac_q     <= '0;
      dac_valid <= 1'b0;
    end else begin
      dac_valid <= cap_vld;
      if (cap_vld) begin
        dac_i <= IQ_DATA_WIDTH'(prod_i >>> k_lat);
        dac_q <= IQ_DATA_WIDTH'(prod_q >>> k_lat);
      end
    end
  end

  assign underrun_evt = strobe && !wifi_iq_valid && (state_nxt != IDLE);

  // Saturating underrun counter; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      underrun_cnt <= '0;
    end else if (underrun_clr) begin
      underrun_cnt <= '0;
    end else if (underrun_evt && underrun_cnt != 16'hFFFF) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

endmodule
